posit_encode_pipe: RTL and testbench

//  Pipelined posit encoder: packs sign/scale/fraction (output of posit arithmetic cores)

---
 rtl/posit_encode_pipe_pkg.sv | 29 ++
 rtl/posit_encode_pipe_if.sv | 36 +++
 rtl/posit_encode_pipe_regime_shift.sv | 40 ++++
 rtl/posit_encode_pipe.sv | 160 ++++++++++++++++
 tb/tb_posit_encode_pipe.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/posit_encode_pipe_pkg.sv
// Shared constants, width helpers and the per-beat control flags for the posit encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package posit_encode_pipe_pkg;

    localparam int PSTWID_DEF = 32;
    localparam int ES_DEF     = 2;

    // Signed scale width: regime count k needs $clog2(PSTWID-1)+2 bits (with sign
    // and room past the clamp limits), plus ES exponent bits below it.
    function automatic int sw_of(input int pstwid, input int es);
        return $clog2(pstwid - 1) + es + 2;
    endfunction

    // Regime count width, i.e. scale with the exponent bits shifted out.
    function automatic int kw_of(input int pstwid, input int es);
        return sw_of(pstwid, es) - es;
    endfunction

    // Special-case flags carried alongside the data through every stage.
    typedef struct packed {
        logic sign;
        logic zero;
        logic nar;
        logic clampmax;
        logic clampmin;
    } flags_t;

endpackage

// File: rtl/posit_encode_pipe_if.sv
// Beat interface of the posit encoder: input stream (sign/scale/fraction) and output posit stream.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both streams; 'slave' is the encoder side, 'master' the environment.
//   in_valid/in_ready, sign_i, zero_i, nar_i, scale_i[SW], frac_i[PSTWID], sticky_i : input beat
//   out_valid/out_ready, o[PSTWID]                                                : encoded posit
interface posit_encode_pipe_if
    import posit_encode_pipe_pkg::*;
#(
    parameter int PSTWID = PSTWID_DEF,
    parameter int ES     = ES_DEF
);
    localparam int SW = sw_of(PSTWID, ES);

    logic              in_valid;
    logic              in_ready;
    logic              sign_i;
    logic              zero_i;
    logic              nar_i;
    logic [SW-1:0]     scale_i;
    logic [PSTWID-1:0] frac_i;
    logic              sticky_i;
    logic              out_valid;
    logic              out_ready;
    logic [PSTWID-1:0] o;

    modport slave (
        input  in_valid, sign_i, zero_i, nar_i, scale_i, frac_i, sticky_i, out_ready,
        output in_ready, out_valid, o
    );

    modport master (
        output in_valid, sign_i, zero_i, nar_i, scale_i, frac_i, sticky_i, out_ready,
        input  in_ready, out_valid, o
    );

endinterface

// File: rtl/posit_encode_pipe_regime_shift.sv
// Builds the regime run followed by exponent and fraction, left-aligned, and splits it into body/guard/sticky.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
//   k[KW] signed regime count, tail[ES+PSTWID] = {e, frac}, sticky -> body[PSTWID-1], g, st
module posit_encode_pipe_regime_shift
    import posit_encode_pipe_pkg::*;
#(
    parameter int PSTWID = PSTWID_DEF,
    parameter int ES     = ES_DEF,
    parameter int KW     = kw_of(PSTWID_DEF, ES_DEF)
) (
    input  logic signed [KW-1:0]        k,
    input  logic        [ES+PSTWID-1:0] tail,
    input  logic                        sticky,
    output logic        [PSTWID-2:0]    body,
    output logic                        g,
    output logic                        st
);
    // Wider than 2*PSTWID so the longest unclamped shift never pushes tail bits
    // off the bottom; everything below the guard bit lands in the sticky OR.
    localparam int FLD = 2 * PSTWID + ES + 2;

    logic                  r0;
    logic [KW-1:0]         sh;
    logic signed [FLD-1:0] base;
    logic signed [FLD-1:0] fld;

    // Seed is {r0, ~r0, tail}. An arithmetic shift by k (k>=0) replicates the
    // leading 1 into k+1 ones then the 0 terminator; for k<0 a shift by -k-1
    // (= ~k) gives -k zeros then the 1 terminator. Run length is R = k+2 / -k+1.
    assign r0   = ~k[KW-1];
    assign sh   = k[KW-1] ? ~k : k;
    assign base = {r0, ~r0, tail, {PSTWID{1'b0}}};
    assign fld  = base >>> sh;

    assign body = fld[FLD-1 -: PSTWID-1];
    assign g    = fld[FLD-PSTWID];
    assign st   = (|fld[FLD-PSTWID-1:0]) | sticky;

endmodule

// File: rtl/posit_encode_pipe.sv
// Pipelined posit encoder: sign/scale/fraction -> PSTWID-bit posit with RNE rounding, clamping and negation.
// Latency: 3 cycles (decode/clamp, regime shift, round/negate), throughput 1 beat per clock.
// Backpressure: each stage loads when it is empty or its successor loads; in_ready is combinational in out_ready.
//   clk, rst (async, active-high)
//   bus : posit_encode_pipe_if.slave (in_valid/in_ready + beat fields, out_valid/out_ready + o)
module posit_encode_pipe
    import posit_encode_pipe_pkg::*;
#(
    parameter int PSTWID = PSTWID_DEF,
    parameter int ES     = ES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    posit_encode_pipe_if.slave bus
);
    localparam int SW = sw_of(PSTWID, ES);
    localparam int KW = kw_of(PSTWID, ES);
    localparam int TW = ES + PSTWID;

    localparam logic signed [KW-1:0] KMAX   = KW'(PSTWID - 2);
    localparam logic [PSTWID-1:0]    MAXPOS = {1'b0, {(PSTWID-1){1'b1}}};
    localparam logic [PSTWID-1:0]    MINPOS = PSTWID'(1);
    localparam logic [PSTWID-1:0]    NAR    = {1'b1, {(PSTWID-1){1'b0}}};

    typedef struct packed {
        flags_t                f;
        logic signed [KW-1:0]  k;
        logic        [TW-1:0]  tail;
        logic                  st;
    } s1_t;

    typedef struct packed {
        flags_t                f;
        logic [PSTWID-2:0]     body;
        logic                  g;
        logic                  st;
    } s2_t;

    logic              v1, v2, v3;
    logic              rdy1, rdy2, rdy3;
    s1_t               s1_q, s1_nxt;
    s2_t               s2_q, s2_nxt;
    logic [PSTWID-1:0] o_q, o_nxt;

    // ---------------- handshake ----------------
    // A stage may load when it is empty or its content moves on this cycle,
    // so bubbles collapse and a full pipe still streams at one beat per clock.
    assign rdy3 = ~v3 | bus.out_ready;
    assign rdy2 = ~v2 | rdy3;
    assign rdy1 = ~v1 | rdy2;

    assign bus.in_ready  = rdy1;
    assign bus.out_valid = v3;
    assign bus.o         = o_q;

    // ---------------- stage 1: split scale, clamp detect ----------------
    logic signed [KW-1:0] k_in;

    // Upper scale bits are exactly scale >>> ES; the low ES bits are the exponent.
    assign k_in = bus.scale_i[SW-1:ES];

    always_comb begin
        s1_nxt            = '0;
        s1_nxt.f.sign     = bus.sign_i;
        s1_nxt.f.zero     = bus.zero_i;
        s1_nxt.f.nar      = bus.nar_i;
        s1_nxt.f.clampmax = (k_in >= KMAX);
        s1_nxt.f.clampmin = (k_in < -KMAX);
        s1_nxt.k          = k_in;
        s1_nxt.tail       = TW'({bus.scale_i, bus.frac_i});
        s1_nxt.st         = bus.sticky_i;
    end

    // ---------------- stage 2: regime run + field assembly ----------------
    logic [PSTWID-2:0] sh_body;
    logic              sh_g;
    logic              sh_st;

    posit_encode_pipe_regime_shift #(
        .PSTWID (PSTWID),
        .ES     (ES),
        .KW     (KW)
    ) u_regime_shift (
        .k      (s1_q.k),
        .tail   (s1_q.tail),
        .sticky (s1_q.st),
        .body   (sh_body),
        .g      (sh_g),
        .st     (sh_st)
    );

    always_comb begin
        s2_nxt      = '0;
        s2_nxt.f    = s1_q.f;
        s2_nxt.body = sh_body;
        s2_nxt.g    = sh_g;
        s2_nxt.st   = sh_st;
    end

    // ---------------- stage 3: RNE, saturation, negation ----------------
    logic              inc;
    logic [PSTWID-1:0] sum;
    logic [PSTWID-1:0] mag;

    always_comb begin
        inc   = s2_q.g & (s2_q.st | s2_q.body[0]);
        sum   = {1'b0, s2_q.body} + {{(PSTWID-1){1'b0}}, inc};
        mag   = sum;
        // Posits saturate: never round into the sign bit (NaR) or down to zero.
        if (sum[PSTWID-1]) begin
            mag = MAXPOS;
        end else if (sum == '0) begin
            mag = MINPOS;
        end
        if (s2_q.f.clampmax) begin
            mag = MAXPOS;
        end else if (s2_q.f.clampmin) begin
            mag = MINPOS;
        end
        o_nxt = s2_q.f.sign ? (~mag + 1'b1) : mag;
        if (s2_q.f.zero) begin
            o_nxt = '0;
        end
        if (s2_q.f.nar) begin
            o_nxt = NAR;
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            o_q  <= '0;
        end else begin
            if (rdy3) begin
                v3 <= v2;
                if (v2) begin
                    o_q <= o_nxt;
                end
            end
            if (rdy2) begin
                v2 <= v1;
                if (v1) begin
                    s2_q <= s2_nxt;
                end
            end
            if (rdy1) begin
                v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_q <= s1_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_posit_encode_pipe.sv
module tb_posit_encode_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    posit_encode_pipe_if #(.PSTWID(8),  .ES(0)) b8  ();
    posit_encode_pipe_if #(.PSTWID(32), .ES(2)) b32 ();

    posit_encode_pipe #(.PSTWID(8),  .ES(0)) dut8  (.clk(clk), .rst(rst), .bus(b8));
    posit_encode_pipe #(.PSTWID(32), .ES(2)) dut32 (.clk(clk), .rst(rst), .bus(b32));

    typedef struct {
        logic [31:0] exp;
        int          cyc;
        bit          lat;
        int          id;
    } sb_t;

    sb_t q8[$];
    sb_t q32[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mode8  = 0;   // out_ready: 0 low, 1 high, 2 random
    int mode32 = 0;
    int beat_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int id, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s #%0d: observed 0x%0h expected 0x%0h", tag, id, obs, exp);
        end
    endtask

    // out_ready driver, updated 2 time units after each rising edge
    initial begin
        b8.out_ready  = 1'b0;
        b32.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            b8.out_ready  = (mode8 == 2)  ? 1'($urandom_range(0, 1)) : (mode8 == 1);
            b32.out_ready = (mode32 == 2) ? 1'($urandom_range(0, 1)) : (mode32 == 1);
        end
    end

    // Scoreboard monitors: sample at the falling edge, pop on each output transfer
    bit          hold8 = 1'b0;
    logic [7:0]  prev_o8;
    always @(negedge clk) begin : mon8
        sb_t e;
        if (rst) begin
            hold8 = 1'b0;
        end else begin
            if (hold8) begin
                chk("hold_valid8", 0, 32'(b8.out_valid), 32'd1);
                chk("hold_o8", 0, 32'(b8.o), 32'(prev_o8));
            end
            if (b8.out_valid && q8.size() == 0) begin
                chk("spurious8", 0, 32'(b8.out_valid), 32'd0);
            end else if (b8.out_valid && b8.out_ready) begin
                e = q8.pop_front();
                chk("o8", e.id, 32'(b8.o), e.exp);
                if (e.lat) chk("latency8", e.id, 32'(cyc - e.cyc), 32'd3);
            end
            hold8   = b8.out_valid && !b8.out_ready;
            prev_o8 = b8.o;
        end
    end

    bit          hold32 = 1'b0;
    logic [31:0] prev_o32;
    always @(negedge clk) begin : mon32
        sb_t e;
        if (rst) begin
            hold32 = 1'b0;
        end else begin
            if (hold32) begin
                chk("hold_valid32", 0, 32'(b32.out_valid), 32'd1);
                chk("hold_o32", 0, b32.o, prev_o32);
            end
            if (b32.out_valid && q32.size() == 0) begin
                chk("spurious32", 0, 32'(b32.out_valid), 32'd0);
            end else if (b32.out_valid && b32.out_ready) begin
                e = q32.pop_front();
                chk("o32", e.id, b32.o, e.exp);
            end
            hold32   = b32.out_valid && !b32.out_ready;
            prev_o32 = b32.o;
        end
    end

    // Bit-serial reference for PSTWID=32, ES=2: emit regime, exponent, fraction, then round.
    function automatic logic [31:0] ref32(input logic sg, input logic z, input logic n,
                                          input int scale, input logic [31:0] fr, input logic st);
        int           k;
        int           e;
        int           nbits;
        logic [127:0] bs;
        logic [30:0]  body;
        logic         g;
        logic         s;
        logic [31:0]  mag;
        if (n) return 32'h8000_0000;
        if (z) return 32'h0;
        k = scale >>> 2;
        e = scale & 3;
        if (k >= 30) begin
            mag = 32'h7FFF_FFFF;
        end else if (k < -30) begin
            mag = 32'h1;
        end else begin
            bs = '0;
            nbits = 0;
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) begin bs = (bs << 1) | 128'd1; nbits++; end
                bs = bs << 1; nbits++;
            end else begin
                for (int i = 0; i < -k; i++) begin bs = bs << 1; nbits++; end
                bs = (bs << 1) | 128'd1; nbits++;
            end
            bs = (bs << 2) | 128'(e);
            bs = (bs << 32) | 128'(fr);
            nbits += 34;
            bs = bs << (128 - nbits);
            body = bs[127:97];
            g    = bs[96];
            s    = (|bs[95:0]) | st;
            if (g && (s || body[0])) begin
                if (&body) mag = 32'h7FFF_FFFF;
                else       mag = {1'b0, body + 31'd1};
            end else begin
                mag = {1'b0, body};
            end
            if (mag == 32'h0) mag = 32'h1;
        end
        return sg ? (~mag + 32'd1) : mag;
    endfunction

    // Drivers: called just after a rising edge; return just after the accepting edge.
    task automatic send8(input logic sg, input logic z, input logic n, input int scale,
                         input logic [7:0] fr, input logic st, input logic [7:0] exp, input bit lat);
        int w;
        int dc;
        b8.sign_i = sg; b8.zero_i = z; b8.nar_i = n;
        b8.scale_i = 5'(scale); b8.frac_i = fr; b8.sticky_i = st;
        b8.in_valid = 1'b1;
        dc = cyc;
        w = 0;
        @(negedge clk);
        while (!b8.in_ready && w < 500) begin @(negedge clk); w++; end
        if (!b8.in_ready) chk("in_ready8_timeout", beat_id, 32'(b8.in_ready), 32'd1);
        @(posedge clk); #1;
        q8.push_back('{32'(exp), dc, lat, beat_id});
        beat_id++;
        b8.in_valid = 1'b0;
    endtask

    task automatic send32(input logic sg, input logic z, input logic n, input int scale,
                          input logic [31:0] fr, input logic st, input logic [31:0] exp);
        int w;
        b32.sign_i = sg; b32.zero_i = z; b32.nar_i = n;
        b32.scale_i = 9'(scale); b32.frac_i = fr; b32.sticky_i = st;
        b32.in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!b32.in_ready && w < 500) begin @(negedge clk); w++; end
        if (!b32.in_ready) chk("in_ready32_timeout", beat_id, 32'(b32.in_ready), 32'd1);
        @(posedge clk); #1;
        q32.push_back('{exp, cyc, 1'b0, beat_id});
        beat_id++;
        b32.in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((q8.size() != 0 || q32.size() != 0) && w < 3000) begin @(posedge clk); w++; end
        if (q8.size() != 0)  chk("drain8", 0, 32'(q8.size()), 32'd0);
        if (q32.size() != 0) chk("drain32", 0, 32'(q32.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    int          t4_scale [10] = '{0, 1, -1, 2, -2, 3, -3, 4, -4, 5};
    logic [7:0]  t4_exp   [10] = '{8'h40, 8'h60, 8'h20, 8'h70, 8'h10, 8'h78, 8'h08, 8'h7C, 8'h04, 8'h7E};

    initial begin
        rst = 1'b1;
        b8.in_valid = 1'b0;  b8.sign_i = 1'b0;  b8.zero_i = 1'b0;  b8.nar_i = 1'b0;
        b8.scale_i = '0;     b8.frac_i = '0;    b8.sticky_i = 1'b0;
        b32.in_valid = 1'b0; b32.sign_i = 1'b0; b32.zero_i = 1'b0; b32.nar_i = 1'b0;
        b32.scale_i = '0;    b32.frac_i = '0;   b32.sticky_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid8", 0, 32'(b8.out_valid), 32'd0);
        chk("rst_o8", 0, 32'(b8.o), 32'd0);
        chk("rst_out_valid32", 0, 32'(b32.out_valid), 32'd0);
        chk("rst_o32", 0, b32.o, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready8", 0, 32'(b8.in_ready), 32'd1);
        chk("rst_in_ready32", 0, 32'(b32.in_ready), 32'd1);
        mode8 = 1; mode32 = 1;
        repeat (2) @(posedge clk);
        #1;

        // Basic encodings, each from an empty pipe so latency is checked
        send8(0, 0, 0,  0, 8'h00, 0, 8'h40, 1); drain();
        send8(0, 0, 0,  1, 8'h00, 0, 8'h60, 1); drain();
        send8(0, 0, 0, -1, 8'h00, 0, 8'h20, 1); drain();
        send8(1, 0, 0,  0, 8'h00, 0, 8'hC0, 1); drain();

        // Round to nearest even, back to back
        send8(0, 0, 0, 0, 8'h80, 0, 8'h50, 0);
        send8(0, 0, 0, 5, 8'h80, 0, 8'h7E, 0);
        send8(0, 0, 0, 5, 8'h80, 1, 8'h7F, 0);
        send8(0, 0, 0, 5, 8'hC0, 0, 8'h7F, 0);
        drain();

        // Clamp limits (a 5-bit scale holds -16..15, so the extremes stand in for +-100)
        send8(0, 0, 0,   6, 8'h00, 0, 8'h7F, 0);
        send8(0, 0, 0,  -6, 8'h00, 0, 8'h01, 0);
        send8(0, 0, 0,  -7, 8'h00, 0, 8'h01, 0);
        send8(0, 0, 0,  15, 8'hFF, 1, 8'h7F, 0);
        send8(0, 0, 0, -16, 8'hFF, 1, 8'h01, 0);
        send8(1, 0, 0,  15, 8'h00, 0, 8'h81, 0);
        send8(1, 1, 0,   3, 8'hA5, 1, 8'h00, 0);
        send8(0, 1, 1,   3, 8'hA5, 0, 8'h80, 0);
        send8(1, 0, 1,  -2, 8'h00, 0, 8'h80, 0);
        drain();

        // Random backpressure on a burst of 10
        mode8 = 2;
        for (int i = 0; i < 10; i++) send8(0, 0, 0, t4_scale[i], 8'h00, 0, t4_exp[i], 0);
        drain();

        // Reset with three beats in flight
        mode8 = 0;
        repeat (2) @(posedge clk);
        #1;
        send8(0, 0, 0, 1, 8'h00, 0, 8'h60, 0);
        send8(0, 0, 0, 2, 8'h00, 0, 8'h70, 0);
        send8(0, 0, 0, 3, 8'h00, 0, 8'h78, 0);
        chk("pre_rst_valid8", 0, 32'(b8.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid8", 0, 32'(b8.out_valid), 32'd0);
        chk("async_rst_o8", 0, 32'(b8.o), 32'd0);
        q8.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mode8 = 1;
        repeat (8) @(posedge clk);
        #1;
        send8(0, 0, 0, 0, 8'h00, 0, 8'h40, 1);
        drain();

        // 32-bit, ES=2
        send32(0, 0, 0,  0, 32'h0, 0, 32'h4000_0000);
        send32(0, 0, 0,  4, 32'h0, 0, 32'h6000_0000);
        send32(0, 0, 0, -1, 32'h0, 0, 32'h3800_0000);
        drain();
        mode32 = 2;
        for (int i = 0; i < 2000; i++) begin
            logic        sg, z, n, st;
            int          sc;
            logic [31:0] fr;
            sg = 1'($urandom_range(0, 1));
            z  = ($urandom_range(0, 31) == 0);
            n  = ($urandom_range(0, 31) == 0);
            st = 1'($urandom_range(0, 1));
            fr = $urandom;
            if ($urandom_range(0, 7) == 0) sc = int'($urandom_range(0, 511)) - 256;
            else                           sc = int'($urandom_range(0, 260)) - 130;
            send32(sg, z, n, sc, fr, st, ref32(sg, z, n, sc, fr, st));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
